pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter AW, default 8: address/offset width in bits, legal 4..32.
REQ-002 SHALL have parameter DEPTH, default 4: return-stack entries, power of two, legal 2..16.
REQ-003 SHALL have parameter RESET_ADDR, default 0: value loaded into the PC on reset or clear.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port clear  input  1  synchronous clear of PC, stack and flags.
REQ-007 SHALL have port inc  input  1  advance PC by one.
REQ-008 SHALL have port load  input  1  absolute jump to target.
REQ-009 SHALL have port branch  input  1  relative jump by signed offset.
REQ-010 SHALL have port call  input  1  push return address, jump to target.
REQ-011 SHALL have port ret  input  1  pop return address into PC.
REQ-012 SHALL have port target  input  AW  absolute destination for load/call.
REQ-013 SHALL have port offset  input  AW  two's-complement branch displacement.
REQ-014 SHALL have port address_out  output  AW  current PC, registered.
REQ-015 SHALL have port flag  output  3  [0] wrap pulse, [1] stack overflow (sticky), [2] stack underflow (sticky).
REQ-016 SHALL have port depth  output  clog2(DEPTH)+1  current number of stacked entries, registered.

Function
REQ-017 SHALL resolve simultaneous commands by fixed priority: clear > ret > call > load > branch > inc; lower-priority commands in that cycle are ignored.
REQ-018 SHALL hold PC, stack, depth and sticky flags when no command is asserted.
REQ-019 SHALL make every command visible on address_out/depth/flag in the cycle after the capturing edge (latency 1, no bypass).
REQ-020 inc: PC <= PC+1 modulo 2^AW; flag[0] SHALL pulse high for exactly one cycle when PC goes from all-ones to zero.
REQ-021 load: PC <= target; flag[0] low.
REQ-022 branch: PC <= PC + offset modulo 2^AW (offset sign-extended); flag[0] SHALL pulse when the signed result leaves 0..2^AW-1 (forward past all-ones or backward below zero).
REQ-023 call, depth < DEPTH: push (PC+1) mod 2^AW, PC <= target, depth+1.
REQ-024 call, depth == DEPTH: no push, PC and depth unchanged, flag[1] SHALL set and remain set.
REQ-025 ret, depth > 0: PC <= top entry, depth-1.
REQ-026 ret, depth == 0: PC and depth unchanged, flag[2] SHALL set and remain set.
REQ-027 Stack SHALL be LIFO: entry returned by ret is the most recently pushed, unpopped address.
REQ-028 clear: PC <= RESET_ADDR, depth <= 0, flag <= 3'b000; stack contents need not be zeroed but SHALL be unreachable.
REQ-029 flag[1]/flag[2] SHALL be cleared only by clear or RST; successful call/ret SHALL NOT clear them.
REQ-030 flag[0] SHALL be low in every cycle not immediately following a wrapping inc or branch.

Reset
REQ-031 RST high SHALL immediately, without a clock edge, force address_out=RESET_ADDR, depth=0, flag=3'b000.
REQ-032 While RST is high all commands SHALL be ignored; first command is taken on the first rising edge after RST falls.
REQ-033 RST asserted mid-sequence (e.g. during consecutive calls) SHALL discard all stacked entries; a later ret SHALL underflow.

Verification (AW=8, DEPTH=4, RESET_ADDR=0)
REQ-034 RST pulse, then inc x3 -> address_out 0x00,0x01,0x02,0x03; flag=000 throughout.
REQ-035 load target=0xFE, inc x2 -> 0xFE,0xFF,0x00; flag[0]=1 only in the 0x00 cycle.
REQ-036 load 0x10, branch offset=0xF6 (-10) -> 0x06; then branch offset=0xF0 (-16) -> 0xF6 with flag[0] pulse.
REQ-037 from PC 0x20, call 0x40,0x50,0x60,0x70 -> depth 4; fifth call 0x80 -> PC stays 0x70, flag[1]=1; ret x4 -> 0x61,0x51,0x41,0x21, depth 0, flag[1] still 1.
REQ-038 ret at depth 0 -> PC unchanged, flag[2]=1; clear -> PC 0x00, depth 0, flag 000.
REQ-039 inc+load+call+ret together at depth 1 (top 0x33) -> PC 0x33, depth 0; async RST mid-cycle -> outputs to reset values before next edge.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack -- program counter with a bounded hardware return stack.
//
// Purpose:
//   Holds the current PC and a LIFO of return addresses. Commands are
//   resolved by fixed priority each cycle:
//   clear > ret > call > load > branch > inc.
//   All results show up on the registered outputs one cycle after the
//   capturing edge.
//
// Ports:
//   CLK          in   1          rising-edge clock
//   RST          in   1          asynchronous active-high reset
//   clear        in   1          synchronous clear of PC, stack depth and flags
//   inc          in   1          PC <= PC + 1
//   load         in   1          PC <= target
//   branch       in   1          PC <= PC + sign-extended offset
//   call         in   1          push PC+1, PC <= target
//   ret          in   1          PC <= popped return address
//   target       in   AW         absolute destination for load/call
//   offset       in   AW         two's-complement branch displacement
//   address_out  out  AW         current PC (registered)
//   flag         out  3          {underflow (sticky), overflow (sticky), wrap pulse}
//   depth        out  IW+1       number of valid stacked entries (registered)
module pc_stack #(
  parameter int AW         = 8,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     inc,
  input  logic                     load,
  input  logic                     branch,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            target,
  input  logic [AW-1:0]            offset,
  output logic [AW-1:0]            address_out,
  output logic [2:0]               flag,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;
  localparam logic [AW-1:0] RST_PC   = AW'(RESET_ADDR);
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  // Command bundle, ordered so the priority chain reads top-down.
  typedef struct packed {
    logic clr;
    logic rt;
    logic cl;
    logic ld;
    logic br;
    logic in;
  } cmd_t;

  cmd_t cmd;
  assign cmd = '{clr: clear, rt: ret, cl: call, ld: load, br: branch, in: inc};

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] dep_q, dep_d;
  logic          wrap_q, wrap_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [AW-1:0] stk_q [DEPTH];

  logic          full, empty;
  logic [AW-1:0] pc_inc;
  logic [AW:0]   br_sum;
  logic          br_wrap;
  logic [DW-1:0] dep_m1;
  logic [IW-1:0] top_idx, push_idx;
  logic          push;

  assign full     = (dep_q == FULL_CNT);
  assign empty    = (dep_q == '0);
  assign pc_inc   = pc_q + AW'(1);
  assign dep_m1   = dep_q - DW'(1);
  assign top_idx  = dep_m1[IW-1:0];
  assign push_idx = dep_q[IW-1:0];

  // Unsigned add with carry out. A non-negative offset wraps when it
  // carries; a negative one (stored as offset+2^AW) wraps below zero
  // exactly when it does not carry, hence the xor with the sign bit.
  assign br_sum  = {1'b0, pc_q} + {1'b0, offset};
  assign br_wrap = br_sum[AW] ^ offset[AW-1];

  always_comb begin
    pc_d   = pc_q;
    dep_d  = dep_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    if (cmd.clr) begin
      pc_d  = RST_PC;
      dep_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (cmd.rt) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = stk_q[top_idx];
        dep_d = dep_m1;
      end
    end else if (cmd.cl) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push  = 1'b1;
        pc_d  = target;
        dep_d = dep_q + DW'(1);
      end
    end else if (cmd.ld) begin
      pc_d = target;
    end else if (cmd.br) begin
      pc_d   = br_sum[AW-1:0];
      wrap_d = br_wrap;
    end else if (cmd.in) begin
      pc_d   = pc_inc;
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q   <= RST_PC;
      dep_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      dep_q  <= dep_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack storage is never cleared; entries at or above dep_q are simply
  // unreachable. RST gates the write so a held reset cannot push.
  always_ff @(posedge CLK) begin
    if (push && !RST) stk_q[push_idx] <= pc_inc;
  end

  assign address_out = pc_q;
  assign depth       = dep_q;
  assign flag        = {unf_q, ovf_q, wrap_q};

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int MOD = 1 << AW;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic clear = 0, inc = 0, load = 0, branch = 0, call = 0, ret = 0;
  logic [AW-1:0] target = '0, offset = '0;
  logic [AW-1:0] address_out;
  logic [2:0]    flag;
  logic [2:0]    depth;

  pc_stack #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .CLK(CLK), .RST(RST), .clear(clear), .inc(inc), .load(load),
    .branch(branch), .call(call), .ret(ret), .target(target),
    .offset(offset), .address_out(address_out), .flag(flag), .depth(depth)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit clr, in, ld, br, cl, rt;
    int tgt, off;
  } cmd_t;

  typedef struct {
    int pc, dep, flg;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: PC as an integer, stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_wrap, m_ovf, m_unf;

  function automatic void model_reset();
    m_pc = 0; m_stk.delete(); m_wrap = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_apply(cmd_t c);
    int s;
    m_wrap = 0;
    if (c.clr) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (c.rt) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_pc = m_stk.pop_back();
    end else if (c.cl) begin
      if (m_stk.size() == DEPTH) m_ovf = 1;
      else begin
        m_stk.push_back((m_pc + 1) % MOD);
        m_pc = c.tgt;
      end
    end else if (c.ld) begin
      m_pc = c.tgt;
    end else if (c.br) begin
      s = m_pc + ((c.off >= MOD / 2) ? c.off - MOD : c.off);
      m_wrap = (s < 0) || (s >= MOD);
      m_pc = (s + MOD) % MOD;
    end else if (c.in) begin
      m_wrap = (m_pc == MOD - 1);
      m_pc = (m_pc + 1) % MOD;
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.pc = m_pc; e.dep = m_stk.size();
    e.flg = {29'd0, m_unf, m_ovf, m_wrap};
    return e;
  endfunction

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic cmd_t mk(bit clr, bit in, bit ld, bit br, bit cl, bit rt, int tgt, int off);
    cmd_t c;
    c.clr = clr; c.in = in; c.ld = ld; c.br = br; c.cl = cl; c.rt = rt;
    c.tgt = tgt; c.off = off;
    return c;
  endfunction

  // Drive one command for one edge; expectation is queued right after the edge.
  task automatic step(cmd_t c);
    clear = c.clr; inc = c.in; load = c.ld; branch = c.br; call = c.cl; ret = c.rt;
    target = AW'(c.tgt); offset = AW'(c.off);
    model_apply(c);
    @(posedge CLK); #1;
    exp_q.push_back(model_exp());
    clear = 0; inc = 0; load = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic idle(); step(mk(0,0,0,0,0,0,0,0)); endtask

  task automatic chk_reset_now(string nm);
    chk({nm, ".pc"},    int'(address_out), 0);
    chk({nm, ".depth"}, int'(depth), 0);
    chk({nm, ".flag"},  int'(flag), 0);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued expectation
  // on each falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("address_out", int'(address_out), e.pc);
      chk("depth", int'(depth), e.dep);
      chk("flag", int'(flag), e.flg);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    model_reset();
    #1;
    chk_reset_now("por");
    // Commands presented while RST is high must be ignored.
    call = 1; target = 8'h55; inc = 1;
    @(posedge CLK); #1;
    chk_reset_now("rst_hold");
    call = 0; inc = 0;
    RST = 0;

    // inc x3 from reset
    repeat (3) step(mk(0,1,0,0,0,0,0,0));
    // load 0xFE, inc x2 with wrap
    step(mk(0,0,1,0,0,0,'hFE,0));
    repeat (2) step(mk(0,1,0,0,0,0,0,0));
    idle();
    // branches: backward no-wrap, backward wrap, forward wrap
    step(mk(0,0,1,0,0,0,'h10,0));
    step(mk(0,0,0,1,0,0,0,'hF6));
    step(mk(0,0,0,1,0,0,0,'hF0));
    step(mk(0,0,0,1,0,0,0,'h0A));
    step(mk(0,0,0,1,0,0,0,'h7F));
    // call chain to full, overflow, then unwind
    step(mk(0,0,1,0,0,0,'h20,0));
    step(mk(0,0,0,0,1,0,'h40,0));
    step(mk(0,0,0,0,1,0,'h50,0));
    step(mk(0,0,0,0,1,0,'h60,0));
    step(mk(0,0,0,0,1,0,'h70,0));
    step(mk(0,0,0,0,1,0,'h80,0));
    repeat (4) step(mk(0,0,0,0,0,1,0,0));
    // underflow, then clear
    step(mk(0,0,0,0,0,1,0,0));
    idle();
    step(mk(1,1,1,0,1,1,'h99,0));
    // priority: inc+load+call+ret at depth 1 with top 0x33
    step(mk(0,0,1,0,0,0,'h32,0));
    step(mk(0,0,0,0,1,0,'h99,0));
    step(mk(0,1,1,0,1,1,'h77,0));
    // async reset mid call sequence
    step(mk(0,0,0,0,1,0,'h10,0));
    step(mk(0,0,0,0,1,0,'h20,0));
    @(negedge CLK); #1;
    RST = 1;
    #1;
    chk_reset_now("async_rst");
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    step(mk(0,0,0,0,0,1,0,0));   // stacked entries gone -> underflow

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      c.clr = ($urandom_range(0, 99) < 2);
      c.rt  = ($urandom_range(0, 3) == 0);
      c.cl  = ($urandom_range(0, 2) == 0);
      c.ld  = ($urandom_range(0, 4) == 0);
      c.br  = ($urandom_range(0, 3) == 0);
      c.in  = ($urandom_range(0, 1) == 0);
      c.tgt = $urandom_range(0, MOD - 1);
      c.off = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 7) == 0) c.tgt = MOD - 1;
      step(c);
    end

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
